// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared FSM encodings and counter width for the PWM capture block
package pwm_capture_pkg;
  localparam int CNT_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser for an async input plus rise/fall pulses
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic s_d_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end
  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~s_d_q;
  assign fall_o = ~s_o & s_d_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of each complete PWM cycle in clk cycles
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int               SYNC_STAGES    = 2,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             level
);
  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;
  logic s, rise, fall;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_latch_q, hi_latch_d;
  logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
  logic valid_q, valid_d, timeout_q, timeout_d;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pwm_in),
    .s_o   (s),
    .rise_o(rise),
    .fall_o(fall)
  );

  // The rise cycle counts as 1, so intervals equal the generator's settings exactly
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_latch_d  = hi_latch_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HIGH: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fall) begin
            hi_latch_d = cnt_q;
            state_d    = ST_LOW;
          end else if (cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end
        end
        ST_LOW: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (rise) begin
            period_d    = cnt_q;
            high_time_d = hi_latch_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = CNT_W'(1);
            state_d     = ST_HIGH;
          end else if (cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end
        end
        default: begin
          cnt_d   = rise ? CNT_W'(1) : '0;
          state_d = rise ? ST_HIGH : ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_latch_q  <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_latch_q  <= hi_latch_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign level     = s;
endmodule
